// File: rtl/cpu_control_fsm.sv
// Multi-cycle RV32I main control unit: Moore FSM sequencing fetch/decode/exec/mem/wb,
// with a mem_ready wait-state handshake, optional wait timeout and a sticky trap state.
module cpu_control_fsm #(
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter int unsigned ENABLE_UPPER = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_cond,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] mem_to_reg,
    output logic       instr_done,
    output logic       trap,
    output logic       trap_cause,
    output logic [2:0] state
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ClsNone,
        ClsLoad,
        ClsStore,
        ClsOp,
        ClsOpImm,
        ClsBranch,
        ClsJal,
        ClsJalr,
        ClsLui,
        ClsAuipc
    } cls_e;

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d, cls_dec;
    logic [CntW-1:0]   wait_q, wait_d;
    logic              trap_cause_q, trap_cause_d;
    logic              mem_wait;
    logic              timed_out;

    always_comb begin
        cls_dec = ClsNone;
        case (opcode)
            7'b0000011: cls_dec = ClsLoad;
            7'b0100011: cls_dec = ClsStore;
            7'b0110011: cls_dec = ClsOp;
            7'b0010011: cls_dec = ClsOpImm;
            7'b1100011: cls_dec = ClsBranch;
            7'b1101111: cls_dec = ClsJal;
            7'b1100111: cls_dec = ClsJalr;
            7'b0110111: cls_dec = (ENABLE_UPPER != 0) ? ClsLui : ClsNone;
            7'b0010111: cls_dec = (ENABLE_UPPER != 0) ? ClsAuipc : ClsNone;
            default:    cls_dec = ClsNone;
        endcase
    end

    assign mem_wait  = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
    // A ready in the limit cycle takes priority since timed_out requires !mem_ready.
    assign timed_out = (MEM_TIMEOUT != 0) && mem_wait && (wait_q == CntW'(MEM_TIMEOUT));

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        trap_cause_d = trap_cause_q;
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (timed_out) begin
                    state_d      = StTrap;
                    trap_cause_d = 1'b1;
                end
            end
            StDecode: begin
                cls_d = cls_dec;
                if (cls_dec == ClsNone) begin
                    state_d      = StTrap;
                    trap_cause_d = 1'b0;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls_q)
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsBranch:         state_d = StFetch;
                    default:           state_d = StWb;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = (cls_q == ClsLoad) ? StWb : StFetch;
                end else if (timed_out) begin
                    state_d      = StTrap;
                    trap_cause_d = 1'b1;
                end
            end
            StWb:   state_d = StFetch;
            StTrap: state_d = StTrap;
            default: begin
                state_d      = StTrap;
                trap_cause_d = 1'b0;
            end
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_wait) begin
            wait_d = wait_q + CntW'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFetch;
            cls_q        <= ClsNone;
            wait_q       <= '0;
            trap_cause_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            wait_q       <= wait_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Outputs decode from state and latched class; reset forces everything low.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        mem_to_reg = 2'b00;
        instr_done = 1'b0;
        trap       = 1'b0;
        trap_cause = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                StDecode: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                StExec: begin
                    case (cls_q)
                        ClsLoad, ClsStore: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 2'b10;
                        end
                        ClsOp: begin
                            alu_src_a = 2'b10;
                            alu_op    = 2'b10;
                        end
                        ClsOpImm: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 2'b10;
                            alu_op    = 2'b11;
                        end
                        ClsLui: begin
                            alu_src_a = 2'b11;
                            alu_src_b = 2'b10;
                        end
                        ClsAuipc: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b10;
                        end
                        ClsBranch: begin
                            alu_src_a = 2'b10;
                            alu_op    = 2'b01;
                            pc_src    = 2'b01;
                            pc_write  = branch_cond;
                        end
                        ClsJal: begin
                            pc_src   = 2'b01;
                            pc_write = 1'b1;
                        end
                        ClsJalr: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 2'b10;
                            pc_src    = 2'b10;
                            pc_write  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    mem_read  = (cls_q == ClsLoad);
                    mem_write = (cls_q == ClsStore);
                end
                StWb: begin
                    reg_write = 1'b1;
                    if (cls_q == ClsLoad) begin
                        mem_to_reg = 2'b01;
                    end else if ((cls_q == ClsJal) || (cls_q == ClsJalr)) begin
                        mem_to_reg = 2'b10;
                    end
                end
                StTrap: trap = 1'b1;
                default: ;
            endcase
            instr_done = (state_d == StFetch) && (state_q != StFetch);
            trap_cause = trap_cause_q;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: default instance plus a MEM_TIMEOUT=3,
// ENABLE_UPPER=0 instance for the upper-immediate trap and timeout cases.
module tb_cpu_control_fsm;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBad    = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, mem_ready, branch_cond;
    logic [6:0] opcode;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg;
    logic       instr_done, trap, trap_cause;
    logic [2:0] state;

    logic       rst_b, mem_ready_b, branch_cond_b;
    logic [6:0] opcode_b;
    logic       pc_write_b, ir_write_b, mem_read_b, mem_write_b, reg_write_b;
    logic [1:0] pc_src_b, alu_src_a_b, alu_src_b_b, alu_op_b, mem_to_reg_b;
    logic       instr_done_b, trap_b, trap_cause_b;
    logic [2:0] state_b;

    int total = 0;
    int bad   = 0;

    cpu_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch_cond(branch_cond), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .trap(trap),
        .trap_cause(trap_cause), .state(state)
    );

    cpu_control_fsm #(.MEM_TIMEOUT(3), .ENABLE_UPPER(0)) dut_b (
        .clk(clk), .rst(rst_b), .opcode(opcode_b), .mem_ready(mem_ready_b),
        .branch_cond(branch_cond_b), .pc_write(pc_write_b), .ir_write(ir_write_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .reg_write(reg_write_b),
        .pc_src(pc_src_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
        .alu_op(alu_op_b), .mem_to_reg(mem_to_reg_b), .instr_done(instr_done_b),
        .trap(trap_b), .trap_cause(trap_cause_b), .state(state_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; opcode = 7'd0; mem_ready = 1'b1; branch_cond = 1'b0;
        rst_b = 1'b1; opcode_b = 7'd0; mem_ready_b = 1'b1; branch_cond_b = 1'b0;
        #2;
        chk("rst_state", 32'(state), 0);
        chk("rst_en", 32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 0);
        chk("rst_trap", 32'({trap, trap_cause}), 0);
        tick(); tick();

        // OP: F D E W
        rst = 1'b0; opcode = OpOp; settle();
        chk("op_f_state", 32'(state), 0);
        chk("op_f_en", 32'({mem_read, ir_write, pc_write, reg_write}), 32'b1110);
        chk("op_f_srcb", 32'(alu_src_b), 1);
        tick();
        chk("op_d_state", 32'(state), 1);
        chk("op_d_ab", 32'({alu_src_a, alu_src_b}), 32'b0110);
        chk("op_d_irw", 32'(ir_write), 0);
        tick();
        chk("op_e_state", 32'(state), 2);
        chk("op_e_aluop", 32'(alu_op), 2);
        chk("op_e_ab", 32'({alu_src_a, alu_src_b}), 32'b1000);
        chk("op_e_rw_done", 32'({reg_write, instr_done}), 0);
        tick();
        chk("op_w_state", 32'(state), 4);
        chk("op_w_rw_done", 32'({reg_write, instr_done}), 32'b11);
        chk("op_w_m2r", 32'(mem_to_reg), 0);
        tick();
        chk("op_next_state", 32'(state), 0);
        chk("op_next_done", 32'({reg_write, instr_done}), 0);

        // LOAD with two MEM wait cycles: F D E M M M W
        opcode = OpLoad; settle();
        tick(); tick();
        chk("ld_e_ab", 32'({alu_src_a, alu_src_b, alu_op}), 32'b101000);
        tick(); mem_ready = 1'b0; settle();
        chk("ld_m1_state", 32'(state), 3);
        chk("ld_m1_rd", 32'({mem_read, mem_write}), 32'b10);
        tick();
        chk("ld_m2_state", 32'(state), 3);
        chk("ld_m2_rd", 32'(mem_read), 1);
        tick(); mem_ready = 1'b1; settle();
        chk("ld_m3_state", 32'(state), 3);
        chk("ld_m3_rd_done", 32'({mem_read, instr_done}), 32'b10);
        tick();
        chk("ld_w_state", 32'(state), 4);
        chk("ld_w_m2r", 32'({mem_to_reg, reg_write, instr_done}), 32'b0111);
        tick();
        chk("ld_next_state", 32'(state), 0);

        // BRANCH taken then not taken: F D E each
        opcode = OpBranch; branch_cond = 1'b1; settle();
        tick(); tick();
        chk("br1_e_state", 32'(state), 2);
        chk("br1_e_pc", 32'({pc_write, pc_src, alu_op, instr_done}), 32'b101011);
        tick();
        chk("br1_next_state", 32'(state), 0);
        branch_cond = 1'b0; settle();
        tick(); tick();
        chk("br2_e_pc", 32'({pc_write, instr_done}), 32'b01);
        tick();
        chk("br2_next_state", 32'(state), 0);

        // JALR
        opcode = OpJalr; settle();
        tick(); tick();
        chk("jalr_e", 32'({pc_src, pc_write, alu_src_a, alu_src_b}), 32'b1011010);
        tick();
        chk("jalr_w", 32'({state, mem_to_reg, reg_write}), 32'b100101);
        tick();

        // STORE: F D E M(ready) retires
        opcode = OpStore; settle();
        tick(); tick(); tick();
        chk("st_m", 32'({state, mem_read, mem_write, instr_done}), 32'b011011);
        tick();
        chk("st_next_state", 32'(state), 0);

        // LUI legal on default instance
        opcode = OpLui; settle();
        tick(); tick();
        chk("lui_e_ab", 32'({alu_src_a, alu_src_b}), 32'b1110);
        tick();
        chk("lui_w_state", 32'(state), 4);
        tick();

        // FETCH wait: no IR/PC write until ready
        mem_ready = 1'b0; settle();
        chk("fw_en", 32'({mem_read, ir_write, pc_write}), 32'b100);
        tick();
        chk("fw_state", 32'(state), 0);
        mem_ready = 1'b1; opcode = OpBad; settle();
        chk("fw_ready_irw", 32'({ir_write, pc_write}), 32'b11);
        tick();
        chk("bad_d_state", 32'(state), 1);
        tick();
        chk("bad_trap", 32'({state, trap, trap_cause}), 32'b10110);
        for (int i = 0; i < 20; i++) begin
            chk("bad_hold",
                32'({state, pc_write, ir_write, mem_read, mem_write, reg_write, instr_done}),
                32'b101000000);
            tick();
        end
        rst = 1'b1; settle();
        chk("bad_rst", 32'({state, trap, trap_cause, mem_read}), 0);
        tick(); rst = 1'b0; settle();
        chk("bad_recover", 32'({state, mem_read}), 32'b0001);

        // Second instance: LUI illegal when upper disabled
        rst_b = 1'b0; opcode_b = OpLui; settle();
        chk("b_lui_f", 32'(state_b), 0);
        tick();
        chk("b_lui_d", 32'(state_b), 1);
        tick();
        chk("b_lui_trap", 32'({state_b, trap_b, trap_cause_b}), 32'b10110);
        chk("b_lui_en", 32'({pc_write_b, ir_write_b, mem_read_b, reg_write_b}), 0);

        // Timeout: 4 FETCH cycles without ready then TRAP cause 1
        rst_b = 1'b1; mem_ready_b = 1'b0; settle();
        chk("b_rst_trap", 32'(trap_b), 0);
        tick(); rst_b = 1'b0; settle();
        chk("b_to_c1", 32'(state_b), 0);
        tick(); tick(); tick();
        chk("b_to_c4", 32'({state_b, mem_read_b}), 32'b0001);
        tick();
        chk("b_to_trap", 32'({state_b, trap_b, trap_cause_b}), 32'b10111);

        // Ready in the limit cycle wins
        rst_b = 1'b1; settle(); tick(); rst_b = 1'b0; settle();
        tick(); tick(); tick();
        mem_ready_b = 1'b1; settle();
        chk("b_lim_irw", 32'(ir_write_b), 1);
        tick();
        chk("b_lim_decode", 32'({state_b, trap_b}), 32'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle RV32I main control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction and drives every datapath select and enable. It succeeds the single-cycle combinational decoder. It adds JAL, JALR, LUI, AUIPC and OP-IMM decoding, a `mem_ready` wait-state handshake with an optional timeout, and an illegal-opcode/timeout trap. It sits between the instruction register opcode field and the multi-cycle datapath (PC, IR, ALU, ALUOut, MDR, register file).

## Interface
- `MEM_TIMEOUT`, 15: maximum wait cycles in FETCH/MEM without `mem_ready`; 0 disables the timeout.
- `ENABLE_UPPER`, 1: 1 means LUI/AUIPC are legal; 0 means they trap as illegal.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 7: IR[6:0]; valid from DECODE onward.
- `mem_ready` input 1: memory has completed the current read or write this cycle.
- `branch_cond` input 1: datapath comparator result for funct3, valid in EXEC.
- `pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write` output 1 each: datapath enables.
- `pc_src` output 2: PC source. 00 = ALU result; 01 = ALUOut (target); 10 = ALU result with bit 0 cleared.
- `alu_src_a` output 2: ALU A operand. 00 = PC; 01 = old PC; 10 = rs1; 11 = zero.
- `alu_src_b` output 2: ALU B operand. 00 = rs2; 01 = constant 4; 10 = immediate.
- `alu_op` output 2: ALU control. 00 = add; 01 = branch compare; 10 = R-type funct decode; 11 = I-type funct decode.
- `mem_to_reg` output 2: write-back source. 00 = ALUOut; 01 = MDR; 10 = old PC + 4 (link).
- `instr_done` output 1: one-cycle pulse when an instruction retires.
- `trap` output 1: sticky. `trap_cause` output 1: 0 = illegal opcode, 1 = memory timeout.
- `state` output 3: current state encoding, for debug.

## Operation
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5. Codes 6 and 7 go to TRAP with `trap_cause` = 0.
- All outputs are Moore outputs (decoded from state and latched opcode class) except where gated by `mem_ready` or `branch_cond` as listed. Unlisted outputs are 0.
- **FETCH**
  - Drives `mem_read`, A = 00, B = 01, `alu_op` = 00, `pc_src` = 00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Goes to DECODE when `mem_ready` = 1.
- **DECODE**
  - Drives A = 01, B = 10, `alu_op` = 00, which precomputes the branch/JAL target into ALUOut.
  - Legal opcodes go to EXEC. Any other opcode goes to TRAP (cause 0).
  - Legal opcodes: 0000011 LOAD, 0100011 STORE, 0110011 OP, 0010011 OP-IMM, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
- **EXEC**, by opcode class:
  - LOAD/STORE: A = 10, B = 10, op 00; next MEM.
  - OP: A = 10, B = 00, op 10; next WB.
  - OP-IMM: A = 10, B = 10, op 11; next WB.
  - LUI: A = 11, B = 10, op 00; next WB.
  - AUIPC: A = 01, B = 10, op 00; next WB.
  - BRANCH: A = 10, B = 00, op 01, `pc_src` = 01, `pc_write` = `branch_cond`; next FETCH (retire).
  - JAL: `pc_src` = 01, `pc_write` = 1; next WB.
  - JALR: A = 10, B = 10, op 00, `pc_src` = 10, `pc_write` = 1; next WB.
- **MEM**
  - LOAD drives `mem_read`; STORE drives `mem_write`. Both hold until `mem_ready`.
  - On `mem_ready`: LOAD goes to WB; STORE goes to FETCH (retire).
- **WB**
  - `reg_write` = 1. `mem_to_reg` = 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - Next FETCH (retire).
- **TRAP**: all enables are 0 and `trap` = 1. The FSM stays in TRAP until `rst`.
- **Wait counter**
  - Width is clog2(MEM_TIMEOUT+1).
  - Increments each FETCH/MEM cycle with `mem_ready` = 0.
  - Clears on any state change.
  - If MEM_TIMEOUT > 0 and the counter equals MEM_TIMEOUT with `mem_ready` still 0, the next state is TRAP (cause 1).
  - `mem_ready` in the same cycle as the limit wins: normal transition, no trap.

## Timing
- `rst` asserted: state goes to FETCH, counter to 0, `trap`/`trap_cause` to 0, and all outputs are forced to 0 while `rst` is high. This includes `mem_read`, overriding the FETCH decode.
- The first FETCH is the first cycle after `rst` deasserts.
- Reset mid-instruction or mid-wait aborts immediately; there are no partial write enables after the edge.
- Instruction latency with zero wait states:
  - BRANCH: 3 cycles.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each `mem_ready`-low cycle in FETCH or MEM adds 1 cycle.
- `instr_done` is high for exactly the cycle in which the FSM is in the retiring state and transitions to FETCH. It is never high in TRAP.
- `ir_write` and `pc_write` in FETCH are asserted only in the `mem_ready` cycle; the IR is never written twice per instruction.

## Test plan
- Reset, then OP (0110011) with `mem_ready` held at 1 -> states 0,1,2,4; `reg_write` = 1 only in cycle 4; `instr_done` pulse in cycle 4; `alu_op` = 10 in EXEC.
- LOAD with `mem_ready` low for 2 cycles in MEM -> `mem_read` held for 3 MEM cycles; WB with `mem_to_reg` = 01; total 7 cycles.
- BRANCH with `branch_cond` = 1, then a second BRANCH with `branch_cond` = 0 -> `pc_write` = 1 with `pc_src` = 01 in the first EXEC; `pc_write` = 0 in the second EXEC; 3 cycles each.
- JALR -> EXEC `pc_src` = 10 and `pc_write` = 1; WB `mem_to_reg` = 10 and `reg_write` = 1.
- Opcode 1111111, plus LUI with ENABLE_UPPER = 0 -> TRAP after DECODE; `trap` = 1, `trap_cause` = 0; all enables 0 for 20 or more cycles; `rst` recovers to FETCH.
- MEM_TIMEOUT = 3 with `mem_ready` stuck at 0 in FETCH -> TRAP entered after 4 FETCH cycles with `trap_cause` = 1. Repeat with `mem_ready` = 1 on the 4th cycle -> DECODE, no trap.
